// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
// Module      : instr_encoder
// Description : Turns instruction requests (kind + register fields +
//               immediate) into 32-bit MIPS-style words. Each word gets a
//               byte address and is held in a 2-entry output FIFO with a
//               valid/ready handshake on both sides.
// Revision    : 1.0 - initial release
//
// Ports
//   clk          sole clock, rising edge
//   rst          synchronous active-high reset
//   in_valid     request present
//   in_ready     request accepted when in_valid & in_ready
//   in_kind      0 add,1 sub,2 and,3 or,4 slt,5 addi,6 subi,7 beq,8 bneq,
//                9 b,10 lw,11 sw,12 nop; 13-15 illegal
//   in_rs/rt/rd  register fields
//   in_imm       immediate / branch offset
//   out_valid    FIFO head valid
//   out_ready    head consumed when out_valid & out_ready
//   out_instr    encoded word at the FIFO head
//   out_addr     byte address of the FIFO head
//   err_illegal  illegal-kind indication
//   count        number of words popped (wraps)
//
// Configuration macro
//   ENC_STICKY_ERR_EN : defined   -> err_illegal is sticky until rst
//                       undefined -> one-cycle pulse per illegal request
// ============================================================================
module instr_encoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_kind,
  input  logic [4:0]  in_rs,
  input  logic [4:0]  in_rt,
  input  logic [4:0]  in_rd,
  input  logic [15:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [15:0] out_addr,
  output logic        err_illegal,
  output logic [15:0] count
);

  // Request kinds
  localparam logic [3:0] c_k_add  = 4'd0;
  localparam logic [3:0] c_k_sub  = 4'd1;
  localparam logic [3:0] c_k_and  = 4'd2;
  localparam logic [3:0] c_k_or   = 4'd3;
  localparam logic [3:0] c_k_slt  = 4'd4;
  localparam logic [3:0] c_k_addi = 4'd5;
  localparam logic [3:0] c_k_subi = 4'd6;
  localparam logic [3:0] c_k_beq  = 4'd7;
  localparam logic [3:0] c_k_bneq = 4'd8;
  localparam logic [3:0] c_k_b    = 4'd9;
  localparam logic [3:0] c_k_lw   = 4'd10;
  localparam logic [3:0] c_k_sw   = 4'd11;
  localparam logic [3:0] c_k_nop  = 4'd12;

  // Opcodes
  localparam logic [5:0] c_op_rtype = 6'b000000;
  localparam logic [5:0] c_op_addi  = 6'b001000;
  localparam logic [5:0] c_op_subi  = 6'b001001;
  localparam logic [5:0] c_op_beq   = 6'b000100;
  localparam logic [5:0] c_op_bneq  = 6'b000101;
  localparam logic [5:0] c_op_b     = 6'b000110;
  localparam logic [5:0] c_op_lw    = 6'b100011;
  localparam logic [5:0] c_op_sw    = 6'b101011;

  // R-type function codes
  localparam logic [5:0] c_fn_add = 6'b100000;
  localparam logic [5:0] c_fn_sub = 6'b100010;
  localparam logic [5:0] c_fn_and = 6'b100100;
  localparam logic [5:0] c_fn_or  = 6'b100101;
  localparam logic [5:0] c_fn_slt = 6'b101010;

  localparam logic [1:0]  c_depth     = 2'd2;
  localparam logic [15:0] c_addr_step = 16'd4;

  // FIFO storage and pointers
  logic [31:0] mem_instr_q [2];
  logic [15:0] mem_addr_q  [2];
  logic        wr_ptr_q, wr_ptr_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic [1:0]  occ_q, occ_d;

  logic [15:0] addr_q, addr_d;
  logic [15:0] count_q, count_d;
  logic        err_q, err_d;

  logic        w_legal;
  logic        w_accept;
  logic        w_push;
  logic        w_pop;
  logic [31:0] w_instr;

  // in_ready looks only at occupancy and rst, never at out_ready, so a full
  // FIFO refuses input even on the cycle its head is being popped.
  assign in_ready = ~rst & (occ_q != c_depth);
  assign w_legal  = (in_kind <= c_k_nop);
  assign w_accept = in_valid & in_ready;
  assign w_push   = w_accept & w_legal;
  assign w_pop    = (occ_q != 2'd0) & out_ready;

  // Instruction encoder
  always_comb begin
    w_instr = 32'h0000_0000;
    unique case (in_kind)
      c_k_add:  w_instr = {c_op_rtype, in_rs, in_rt, in_rd, 5'b00000, c_fn_add};
      c_k_sub:  w_instr = {c_op_rtype, in_rs, in_rt, in_rd, 5'b00000, c_fn_sub};
      c_k_and:  w_instr = {c_op_rtype, in_rs, in_rt, in_rd, 5'b00000, c_fn_and};
      c_k_or:   w_instr = {c_op_rtype, in_rs, in_rt, in_rd, 5'b00000, c_fn_or};
      c_k_slt:  w_instr = {c_op_rtype, in_rs, in_rt, in_rd, 5'b00000, c_fn_slt};
      c_k_addi: w_instr = {c_op_addi, in_rs, in_rt, in_imm};
      c_k_subi: w_instr = {c_op_subi, in_rs, in_rt, in_imm};
      c_k_beq:  w_instr = {c_op_beq,  in_rs, in_rt, in_imm};
      c_k_bneq: w_instr = {c_op_bneq, in_rs, in_rt, in_imm};
      c_k_b:    w_instr = {c_op_b, 5'b00000, 5'b00000, in_imm};
      c_k_lw:   w_instr = {c_op_lw, in_rs, in_rt, in_imm};
      c_k_sw:   w_instr = {c_op_sw, in_rs, in_rt, in_imm};
      default:  w_instr = 32'h0000_0000;  // nop, and don't-care for illegal
    endcase
  end

  // Next-state for pointers, occupancy, counters and error flag
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    addr_d   = addr_q;
    count_d  = count_q;
    err_d    = err_q;

    if (w_push) begin
      wr_ptr_d = ~wr_ptr_q;
      addr_d   = addr_q + c_addr_step;  // 0xFFFC wraps to 0x0000 naturally
    end
    if (w_pop) begin
      rd_ptr_d = ~rd_ptr_q;
      count_d  = count_q + 16'd1;
    end

    unique case ({w_push, w_pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;           // idle, or push and pop together
    endcase

`ifdef ENC_STICKY_ERR_EN
    err_d = err_q | (w_accept & ~w_legal);
`else
    err_d = w_accept & ~w_legal;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_instr_q[0] <= 32'h0000_0000;
      mem_instr_q[1] <= 32'h0000_0000;
      mem_addr_q[0]  <= 16'h0000;
      mem_addr_q[1]  <= 16'h0000;
      wr_ptr_q       <= 1'b0;
      rd_ptr_q       <= 1'b0;
      occ_q          <= 2'd0;
      addr_q         <= 16'h0000;
      count_q        <= 16'h0000;
      err_q          <= 1'b0;
    end else begin
      if (w_push) begin
        mem_instr_q[wr_ptr_q] <= w_instr;
        mem_addr_q[wr_ptr_q]  <= addr_q;
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      addr_q   <= addr_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

  // Head entry is read straight from storage; it cannot change while it is
  // not being popped because writes only ever target the other slot.
  assign out_valid   = (occ_q != 2'd0);
  assign out_instr   = mem_instr_q[rd_ptr_q];
  assign out_addr    = mem_addr_q[rd_ptr_q];
  assign err_illegal = err_q;
  assign count       = count_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_encoder
// Description : Self-checking bench for instr_encoder. A queue-based model
//               predicts every output each cycle; directed sequences pin
//               literal encodings, back-pressure, illegal kinds, address
//               wrap and reset behaviour, with random traffic in between.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_encoder;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_kind;
  logic [4:0]  in_rs, in_rt, in_rd;
  logic [15:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [15:0] out_addr;
  logic        err_illegal;
  logic [15:0] count;

  int total = 0;
  int bad   = 0;

  instr_encoder dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_kind     (in_kind),
    .in_rs       (in_rs),
    .in_rt       (in_rt),
    .in_rd       (in_rd),
    .in_imm      (in_imm),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_instr   (out_instr),
    .out_addr    (out_addr),
    .err_illegal (err_illegal),
    .count       (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Word encoding from the instruction-set tables, built arithmetically.
  function automatic logic [31:0] enc(input int k, input int rs, input int rt,
                                      input int rd, input int imm);
    logic [31:0] f, op, r;
    r = 32'(rs) * 32'h0020_0000 + 32'(rt) * 32'h0001_0000;
    case (k)
      0, 1, 2, 3, 4: begin
        case (k)
          0: f = 32;
          1: f = 34;
          2: f = 36;
          3: f = 37;
          default: f = 42;
        endcase
        return r + 32'(rd) * 32'd2048 + f;
      end
      9:  return 32'd6 * 32'h0400_0000 + 32'(imm);
      12: return 32'd0;
      default: begin
        case (k)
          5: op = 8;
          6: op = 9;
          7: op = 4;
          8: op = 5;
          10: op = 35;
          default: op = 43;
        endcase
        return op * 32'h0400_0000 + r + 32'(imm);
      end
    endcase
  endfunction

  logic [47:0] mq[$];     // {instr, addr}, head at index 0
  logic [15:0] maddr;
  logic [15:0] mcount;
  logic        merr;
  bit          mvalid = 0;
  bit          m_pop, m_acc;

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      maddr  = 16'h0000;
      mcount = 16'h0000;
      merr   = 1'b0;
      mvalid = 1;
    end else if (mvalid) begin
      m_pop = (mq.size() != 0) && out_ready;
      m_acc = in_valid && (mq.size() < 2);
      if (m_pop) begin
        void'(mq.pop_front());
        mcount = mcount + 16'd1;
      end
      if (m_acc && in_kind <= 4'd12) begin
        mq.push_back({enc(int'(in_kind), int'(in_rs), int'(in_rt), int'(in_rd),
                          int'(in_imm)), maddr});
        maddr = maddr + 16'd4;
      end
`ifdef ENC_STICKY_ERR_EN
      merr = merr | (m_acc && in_kind > 4'd12);
`else
      merr = m_acc && in_kind > 4'd12;
`endif
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (mvalid) begin
      chk("in_ready", {31'd0, in_ready}, {31'd0, (!rst && mq.size() < 2)});
      chk("out_valid", {31'd0, out_valid}, {31'd0, mq.size() != 0});
      if (mq.size() != 0) begin
        chk("out_instr", out_instr, mq[0][47:16]);
        chk("out_addr", {16'd0, out_addr}, {16'd0, mq[0][15:0]});
      end
      chk("count", {16'd0, count}, {16'd0, mcount});
      chk("err_illegal", {31'd0, err_illegal}, {31'd0, merr});
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input int k, input int rs, input int rt, input int rd, input int imm);
    in_valid = 1'b1;
    in_kind  = 4'(k);
    in_rs    = 5'(rs);
    in_rt    = 5'(rt);
    in_rd    = 5'(rd);
    in_imm   = 16'(imm);
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_kind = 4'd0; in_rs = 5'd0; in_rt = 5'd0; in_rd = 5'd0; in_imm = 16'd0;

    // Reset state, with a request presented during reset that must be dropped
    step();
    req(5, 1, 2, 0, 5);
    step();
    step();
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_addr", {16'd0, out_addr}, 32'd0);
    chk("rst_count", {16'd0, count}, 32'd0);
    chk("rst_err", {31'd0, err_illegal}, 32'd0);
    rst = 1'b0; in_valid = 1'b0;
    step();
    chk("drop_during_rst", {31'd0, out_valid}, 32'd0);
    chk("ready_after_rst", {31'd0, in_ready}, 32'd1);

    // addi after reset
    do_reset();
    out_ready = 1'b1;
    req(5, 1, 2, 0, 16'h0005);
    step();
    in_valid = 1'b0;
    chk("addi_valid", {31'd0, out_valid}, 32'd1);
    chk("addi_instr", out_instr, 32'h2022_0005);
    chk("addi_addr", {16'd0, out_addr}, 32'h0);
    step();

    // add then lw, count reaches 2
    do_reset();
    out_ready = 1'b1;
    req(0, 1, 2, 3, 0);
    step();
    chk("add_instr", out_instr, 32'h0022_1820);
    chk("add_addr", {16'd0, out_addr}, 32'h0);
    req(10, 4, 5, 0, 16'h0010);
    step();
    in_valid = 1'b0;
    chk("lw_instr", out_instr, 32'h8C85_0010);
    chk("lw_addr", {16'd0, out_addr}, 32'h4);
    step();
    chk("count_two", {16'd0, count}, 32'd2);

    // Back-pressure with three beq requests
    do_reset();
    out_ready = 1'b0;
    req(7, 1, 1, 0, 16'hFFFF);
    step();
    step();
    chk("full_ready", {31'd0, in_ready}, 32'd0);
    chk("beq_instr", out_instr, 32'h1021_FFFF);
    step();
    chk("full_ready_hold", {31'd0, in_ready}, 32'd0);
    chk("beq_hold", out_instr, 32'h1021_FFFF);
    out_ready = 1'b1;
    step();
    step();
    in_valid = 1'b0;
    step();
    chk("beq_none_lost", {16'd0, count}, 32'd3);
    chk("beq_drained", {31'd0, out_valid}, 32'd0);

    // Illegal kind then nop
    do_reset();
    out_ready = 1'b1;
    req(14, 3, 3, 3, 16'h1234);
    step();
    req(12, 0, 0, 0, 0);
    chk("illegal_err", {31'd0, err_illegal}, 32'd1);
    chk("illegal_not_pushed", {31'd0, out_valid}, 32'd0);
    step();
    in_valid = 1'b0;
`ifdef ENC_STICKY_ERR_EN
    chk("err_after_nop", {31'd0, err_illegal}, 32'd1);
`else
    chk("err_after_nop", {31'd0, err_illegal}, 32'd0);
`endif
    chk("nop_valid", {31'd0, out_valid}, 32'd1);
    chk("nop_instr", out_instr, 32'h0);
    chk("nop_addr", {16'd0, out_addr}, 32'h0);
    step();

    // Random traffic, occasional mid-operation reset
    for (int i = 0; i < 4000; i++) begin
      rst       = ($urandom_range(0, 199) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) != 0)
        req($urandom_range(0, 15), $urandom_range(0, 31), $urandom_range(0, 31),
            $urandom_range(0, 31), $urandom_range(0, 65535));
      else
        in_valid = 1'b0;
      step();
    end
    rst = 1'b0;

    // Address wrap after 16383 pushes, then reset with a full FIFO
    do_reset();
    out_ready = 1'b1;
    req(12, 0, 0, 0, 0);
    for (int i = 0; i < 16383; i++) step();
    in_valid = 1'b0;
    step();
    out_ready = 1'b0;
    req(1, 7, 8, 9, 0);
    step();
    in_valid = 1'b0;
    chk("wrap_addr_fffc", {16'd0, out_addr}, 32'h0000_FFFC);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    req(9, 1, 2, 3, 16'h0040);
    step();
    in_valid = 1'b0;
    chk("wrap_addr_0000", {16'd0, out_addr}, 32'h0);
    chk("b_instr", out_instr, 32'h1800_0040);
    req(12, 0, 0, 0, 0);
    step();
    in_valid = 1'b0;
    chk("full_before_rst", {31'd0, in_ready}, 32'd0);
    rst = 1'b1;
    step();
    chk("rst_flush_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_flush_count", {16'd0, count}, 32'd0);
    rst = 1'b0;
    step();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have ports in this order: clk, rst, in_valid, in_ready, in_kind, in_rs, in_rt, in_rd, in_imm, out_valid, out_ready, out_instr, out_addr, err_illegal, count.
REQ-002 SHALL use one clock and a synchronous, active-high reset.
REQ-003 SHALL provide the following ports:
- clk  in  1  — sole clock; all state changes on rising edge.
- rst  in  1  — synchronous, active-high reset.
- in_valid  in  1  — request present.
- in_ready  out  1  — request accepted on a cycle with in_valid=1 and in_ready=1.
- in_kind  in  4  — 0 add, 1 sub, 2 and, 3 or, 4 slt, 5 addi, 6 subi, 7 beq, 8 bneq, 9 b, 10 lw, 11 sw, 12 nop; 13-15 illegal.
- in_rs / in_rt / in_rd  in  5 each  — register fields.
- in_imm  in  16  — immediate or branch offset.
- out_valid  out  1  — encoded word available.
- out_ready  in  1  — word consumed on a cycle with out_valid=1 and out_ready=1.
- out_instr  out  32  — encoded instruction.
- out_addr  out  16  — byte address assigned to out_instr.
- err_illegal  out  1  — illegal-kind indication.
- count  out  16  — number of words popped.

Function
REQ-004 R-type encoding SHALL be: opcode 000000, rs, rt, rd, shamt 00000, funct (add 100000, sub 100010, and 100100, or 100101, slt 101010).
REQ-005 I-type encoding SHALL be: {opcode, rs, rt, imm}, with opcodes addi 001000, subi 001001, beq 000100, bneq 000101, lw 100011, sw 101011.
REQ-006 b SHALL encode as {000110, 00000, 00000, imm}; rs and rt inputs are ignored.
REQ-007 nop SHALL encode as 32'h00000000.
REQ-008 Output buffering SHALL be a 2-entry FIFO storing instr and addr; occupancy 0..2.
REQ-009 in_ready SHALL be 1 when occupancy < 2 and SHALL NOT depend combinationally on out_ready.
REQ-010 Latency SHALL be: an accepted legal request with the FIFO empty gives out_valid=1 on the next cycle.
REQ-011 out_valid SHALL equal (occupancy != 0); out_instr/out_addr SHALL show the head entry and hold stable while out_valid=1 and out_ready=0.
REQ-012 On a simultaneous push and pop, occupancy SHALL be unchanged and FIFO order preserved.
REQ-013 The address counter SHALL start at 0x0000 and be tagged onto each pushed word.
REQ-014 The address counter SHALL increment by 4 per push only and wrap 0xFFFC -> 0x0000.
REQ-015 An accepted illegal kind SHALL be consumed: not pushed, address counter unchanged.
REQ-016 count SHALL increment on each pop and wrap 0xFFFF -> 0x0000.

Reset
REQ-017 On a cycle with rst=1, the block SHALL set occupancy 0, address counter 0x0000, count 0x0000, err_illegal 0, out_valid 0, out_instr 0, out_addr 0, and in_ready 0.
REQ-018 in_ready SHALL be 1 from the first cycle after rst deasserts.
REQ-019 A request presented during rst SHALL be dropped.
REQ-020 Reset mid-operation SHALL discard buffered words without producing a pop.

Configuration
REQ-021 Macro ENC_STICKY_ERR_EN defined: err_illegal SHALL go to 1 the cycle after the first accepted illegal request and hold until rst.
REQ-022 Macro ENC_STICKY_ERR_EN undefined: err_illegal SHALL pulse 1 for exactly one cycle after each accepted illegal request.
REQ-023 All other behaviour SHALL be identical with or without ENC_STICKY_ERR_EN.

Verification
REQ-024 addi rs=1, rt=2, imm=0x0005 after reset, out_ready=1 -> next cycle out_valid=1, out_instr=0x20220005, out_addr=0x0000.
REQ-025 add rs=1, rt=2, rd=3, then lw rs=4, rt=5, imm=0x0010 -> 0x00221820 @0x0000, then 0x8C850010 @0x0004; count=2.
REQ-026 out_ready=0 with three back-to-back beq rs=1, rt=1, imm=0xFFFF -> in_ready=0 after two pushes; out_instr held at 0x1021FFFF; no word lost once out_ready=1.
REQ-027 in_kind=14 accepted, then nop -> err_illegal set (one-cycle pulse or sticky per macro); nop emitted as 0x00000000 at address 0x0000.
REQ-028 Address counter preset by 16383 pushes, then two more pushes -> out_addr 0xFFFC then 0x0000; rst asserted with occupancy 2 -> out_valid=0 next cycle, count=0.
